uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter (Tx_Data / Transmit_Start / Tx_Busy handshake) among
//  NUM_REQ on-chip requesters using round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NUM_REQ clients
// Grants one byte at a time, holds Transmit_Start until Tx_Busy rises, then waits for it to fall.
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_BITS     = 8,
   parameter int START_TIMEOUT = 16
) (
   input  logic                         Clk,
   input  logic                         Rst_n,
   input  logic [NUM_REQ-1:0]           Req,
   input  logic [NUM_REQ*DATA_BITS-1:0] Req_Data,
   output logic [NUM_REQ-1:0]           Ack,
   input  logic                         CTS,
   input  logic                         BIST_Busy,
   input  logic                         Tx_Busy,
   output logic [DATA_BITS-1:0]         Tx_Data,
   output logic                         Transmit_Start,
   output logic                         Arb_Busy,
   output logic                         Done,
   output logic [$clog2(NUM_REQ)-1:0]   Done_Id,
   output logic                         Timeout_Err
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(START_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic [1:0] {IDLE, START, SENDING} state_t;

   state_t               state;
   logic [ID_W-1:0]      last_grant;
   logic [CNT_W-1:0]     count;
   logic [ID_W-1:0]      winner;
   logic                 winner_vld;
   logic                 grant_ok;
   logic [DATA_BITS-1:0] sel_data;
   int                   idx;

   // Rotating priority: search starts just above the previous winner and wraps.
   always_comb begin
      winner     = '0;
      winner_vld = 1'b0;
      idx        = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant) + k) % NUM_REQ;
         if (!winner_vld && Req[ID_W'(idx)]) begin
            winner     = ID_W'(idx);
            winner_vld = 1'b1;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == ID_W'(i)) begin
            sel_data = Req_Data[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

   assign grant_ok = winner_vld && CTS && !BIST_Busy && !Tx_Busy;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state          <= IDLE;
         last_grant     <= ID_LAST;
         count          <= '0;
         Tx_Data        <= '0;
         Transmit_Start <= 1'b0;
         Ack            <= '0;
         Arb_Busy       <= 1'b0;
         Done           <= 1'b0;
         Done_Id        <= '0;
         Timeout_Err    <= 1'b0;
      end else begin
         Ack         <= '0;
         Done        <= 1'b0;
         Timeout_Err <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_ok) begin
                  Tx_Data        <= sel_data;
                  Ack            <= ONE_HOT0 << winner;
                  Transmit_Start <= 1'b1;
                  last_grant     <= winner;
                  count          <= '0;
                  Arb_Busy       <= 1'b1;
                  state          <= START;
               end
            end
            START: begin
               // Tx_Busy is checked first so a late handshake on the last cycle still counts.
               if (Tx_Busy) begin
                  Transmit_Start <= 1'b0;
                  count          <= '0;
                  state          <= SENDING;
               end else if (count == CNT_LAST) begin
                  Transmit_Start <= 1'b0;
                  Timeout_Err    <= 1'b1;
                  Done_Id        <= last_grant;
                  count          <= '0;
                  Arb_Busy       <= 1'b0;
                  state          <= IDLE;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            SENDING: begin
               if (!Tx_Busy) begin
                  Done     <= 1'b1;
                  Done_Id  <= last_grant;
                  Arb_Busy <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               Transmit_Start <= 1'b0;
               Arb_Busy       <= 1'b0;
               count          <= '0;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a UART transmitter model
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DB = 8;
   localparam int TO = 16;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*DB-1:0] req_data = '0;
   logic [N-1:0]    ack;
   logic            cts = 1'b1;
   logic            bist_busy = 1'b0;
   logic            tx_busy = 1'b0;
   logic [DB-1:0]   tx_data;
   logic            transmit_start;
   logic            arb_busy;
   logic            done;
   logic [IW-1:0]   done_id;
   logic            timeout_err;

   int errors = 0;
   int checks = 0;

   logic rand_en  = 1'b0;
   logic tx_never = 1'b0;
   int   tx_delay = 2;
   int   tx_len   = 10;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .START_TIMEOUT(TO)) dut (
      .Clk(clk), .Rst_n(rst_n), .Req(req), .Req_Data(req_data), .Ack(ack),
      .CTS(cts), .BIST_Busy(bist_busy), .Tx_Busy(tx_busy), .Tx_Data(tx_data),
      .Transmit_Start(transmit_start), .Arb_Busy(arb_busy), .Done(done),
      .Done_Id(done_id), .Timeout_Err(timeout_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         if (r[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic int oh2i(input logic [N-1:0] a);
      for (int i = 0; i < N; i++) if (a[i]) return i;
      return -1;
   endfunction

   // UART transmitter model: Tx_Busy rises tx_delay cycles after Transmit_Start, lasts tx_len.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (transmit_start && !tx_busy && !tx_never) begin
            repeat (tx_delay - 1) @(posedge clk);
            #1 tx_busy = 1'b1;
            repeat (tx_len) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   // Scoreboard: expected grants from the spec's round-robin rule, completions from a FIFO.
   logic [N-1:0]    prev_req;
   logic [N*DB-1:0] prev_data;
   logic            prev_cts, prev_bist, prev_txb;
   logic            prev_ok = 1'b0;
   logic            m_busy;
   int              m_last;
   logic [DB-1:0]   m_data;
   int              done_q[$];
   int              start_len;

   always @(negedge clk) begin
      logic [N-1:0] exp_ack;
      int g;
      int e;
      if (!rst_n) begin
         m_busy    = 1'b0;
         m_last    = N - 1;
         m_data    = '0;
         start_len = 0;
         done_q.delete();
         prev_ok   = 1'b0;
      end else begin
         if (prev_ok) begin
            exp_ack = '0;
            g = -1;
            if (!m_busy && (prev_req != '0) && prev_cts && !prev_bist && !prev_txb) begin
               g = rr_pick(prev_req, m_last);
               exp_ack = N'(1) << g;
            end
            chk("ack_grant", ack, exp_ack);
            if (g >= 0) begin
               m_busy = 1'b1;
               m_last = g;
               m_data = prev_data[g*DB +: DB];
               done_q.push_back(g);
               chk("start_on_grant", transmit_start, 1'b1);
            end
            chk("tx_data", tx_data, m_data);
            if (done || timeout_err) begin
               chk("done_xor_timeout", done & timeout_err, 1'b0);
               chk(done ? "done_expected" : "timeout_expected", tx_never, done ? 1'b0 : 1'b1);
               if (done_q.size() == 0) begin
                  chk("completion_without_grant", 1'b1, 1'b0);
               end else begin
                  e = done_q.pop_front();
                  chk("done_id", done_id, e);
               end
               m_busy = 1'b0;
            end
            chk("arb_busy", arb_busy, m_busy);
            if (transmit_start) start_len++;
            else if (start_len != 0) begin
               chk("start_len", start_len, tx_never ? TO : tx_delay);
               start_len = 0;
            end
         end
         prev_ok = 1'b1;
      end
      prev_req  = req;
      prev_data = req_data;
      prev_cts  = cts;
      prev_bist = bist_busy;
      prev_txb  = tx_busy;
   end

   task automatic drive_rand();
      if ($urandom_range(0, 19) == 0) cts = ~cts;
      if ($urandom_range(0, 29) == 0) bist_busy = ~bist_busy;
      for (int i = 0; i < N; i++) begin
         if (ack[i]) begin
            req[i] = 1'($urandom_range(0, 1));
            req_data[i*DB +: DB] = DB'($urandom);
         end else if (req[i] && $urandom_range(0, 49) == 0) begin
            req[i] = 1'b0;
         end else if (!req[i] && $urandom_range(0, 7) == 0) begin
            req[i] = 1'b1;
            req_data[i*DB +: DB] = DB'($urandom);
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk); #1;
      if (rand_en) drive_rand();
   endtask

   task automatic wait_ack(input string name, output logic [N-1:0] a);
      int n;
      n = 0;
      do begin cycle(); n++; end while (ack == '0 && n < 300);
      a = ack;
      if (ack == '0) begin
         checks++;
         errors++;
         $display("FAIL %s no Ack within %0d cycles", name, n);
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((arb_busy || tx_busy) && n < 300) begin cycle(); n++; end
      if (arb_busy || tx_busy) begin
         checks++;
         errors++;
         $display("FAIL %s still busy after %0d cycles", name, n);
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] a;
      int n;
      int order[6];
      int exp_order[6];
      exp_order = '{0, 1, 2, 3, 0, 1};

      repeat (3) cycle();
      chk("rst_ack", ack, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_start", transmit_start, 0);
      chk("rst_arb_busy", arb_busy, 0);
      chk("rst_done", done, 0);
      chk("rst_done_id", done_id, 0);
      chk("rst_timeout", timeout_err, 0);
      rst_n = 1'b1;
      cycle();

      // Single byte from requester 1.
      tx_delay = 2; tx_len = 10;
      req_data[15:8] = 8'hA5;
      req = 4'b0010;
      wait_ack("t1_ack", a);
      chk("t1_ack", a, 4'b0010);
      chk("t1_tx_data", tx_data, 8'hA5);
      req = '0;
      n = 1;
      while (n < 100) begin cycle(); if (!transmit_start) break; n++; end
      chk("t1_start_cycles", n, 2);
      n = 0;
      while (!done && n < 100) begin cycle(); n++; end
      chk("t1_done", done, 1);
      chk("t1_done_id", done_id, 1);
      cycle();
      chk("t1_tx_data_hold", tx_data, 8'hA5);

      // Round-robin order with all requesters held.
      pulse_reset();
      for (int i = 0; i < N; i++) req_data[i*DB +: DB] = DB'($urandom);
      req = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         wait_ack("t2_ack", a);
         order[k] = oh2i(a);
         req_data[order[k]*DB +: DB] = DB'($urandom);
      end
      for (int k = 0; k < 6; k++) chk("t2_order", order[k], exp_order[k]);
      req = '0;
      wait_idle("t2_idle");
      cycle();

      // CTS and BIST_Busy gating.
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) cts = 1'b0; else bist_busy = 1'b1;
         req_data[7:0] = 8'h5A + 8'(pass);
         req = 4'b0001;
         n = 0;
         repeat (20) begin cycle(); if (ack != '0 || transmit_start) n++; end
         chk(pass == 0 ? "t3_cts_block" : "t3_bist_block", n, 0);
         cts = 1'b1;
         bist_busy = 1'b0;
         cycle();
         chk(pass == 0 ? "t3_cts_release" : "t3_bist_release", ack, 4'b0001);
         req = '0;
         wait_idle("t3_idle");
         cycle();
      end

      // Start timeout: transmitter never answers.
      tx_never = 1'b1;
      req_data[23:16] = 8'hC3;
      req = 4'b0100;
      wait_ack("t4_ack", a);
      chk("t4_ack", a, 4'b0100);
      req = '0;
      n = 1;
      while (n < 100) begin cycle(); if (!transmit_start) break; n++; end
      chk("t4_start_cycles", n, TO);
      chk("t4_timeout", timeout_err, 1);
      chk("t4_done", done, 0);
      chk("t4_done_id", done_id, 2);
      cycle();
      chk("t4_idle", arb_busy, 0);
      chk("t4_timeout_pulse", timeout_err, 0);
      tx_never = 1'b0;
      cycle();

      // Asynchronous reset in SENDING.
      req_data[7:0] = 8'h3C;
      req = 4'b0001;
      wait_ack("t5_ack", a);
      req = '0;
      n = 0;
      while (!tx_busy && n < 50) begin cycle(); n++; end
      cycle();
      chk("t5_in_sending", arb_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_ack", ack, 0);
      chk("t5_tx_data", tx_data, 0);
      chk("t5_start", transmit_start, 0);
      chk("t5_arb_busy", arb_busy, 0);
      chk("t5_done", done, 0);
      chk("t5_timeout", timeout_err, 0);
      cycle();
      req_data[7:0] = 8'h11;
      req_data[31:24] = 8'h99;
      req = 4'b1001;
      cycle();
      rst_n = 1'b1;
      wait_ack("t5_first", a);
      chk("t5_first_grant", a, 4'b0001);
      req[0] = 1'b0;
      wait_ack("t5_second", a);
      chk("t5_second_grant", a, 4'b1000);
      req = '0;
      wait_idle("t5_idle");
      cycle();

      // Requester 0 re-requests, then withdraws as Tx_Busy falls.
      req_data[7:0] = 8'h21;
      req_data[15:8] = 8'h42;
      req = 4'b0011;
      wait_ack("t6_ack0", a);
      chk("t6_ack0", a, 4'b0001);
      req_data[7:0] = 8'h77;
      n = 0;
      while (!tx_busy && n < 50) begin cycle(); n++; end
      n = 0;
      while (n < 50) begin cycle(); #1; if (!tx_busy) break; n++; end
      req[0] = 1'b0;
      wait_ack("t6_ack1", a);
      chk("t6_ack1", a, 4'b0010);
      req = '0;
      wait_idle("t6_idle");
      cycle();

      // Randomised traffic with varying transmitter timing.
      for (int ph = 0; ph < 3; ph++) begin
         tx_delay = $urandom_range(1, 4);
         tx_len   = $urandom_range(1, 6);
         rand_en  = 1'b1;
         repeat (800) cycle();
         rand_en   = 1'b0;
         req       = '0;
         cts       = 1'b1;
         bist_busy = 1'b0;
         wait_idle("rand_idle");
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
